multicycle_control: RTL and testbench

Moore-style main control FSM for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives every datapath enable and mux select. It also produces the 4-bit ALUOp code consumed by the ALU control decoder. It sits between the instruction register's opcode field and the datapath.

---
 rtl/multicycle_control.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for a multi-cycle MIPS datapath. Each instruction is
// sequenced through fetch, decode, execute, memory and writeback steps. The
// block drives every datapath enable and mux select, and it generates the
// 4-bit ALUOp code that the ALU control decoder consumes.
//
// Ports
//   CLK          in   sole clock, rising edge
//   Reset_L      in   asynchronous active-low reset
//   Opcode[5:0]  in   instruction bits [31:26] from the instruction register
//   Zero         in   ALU zero flag, used only for the branch PC enable
//   ALUOp[3:0]   out  ALU control code
//   IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
//   ALUSrcA, PCWrite, PCWriteCond  out  datapath controls
//   ALUSrcB[1:0] out  ALU B operand select
//   PCSource[1:0]out  PC source select
//   PCEn         out  PCWrite | (PCWriteCond & Zero), combinational
//   IllegalOp    out  single-cycle pulse in DECODE for an unsupported opcode
//   State[3:0]   out  current state, for debug
//
// The Moore outputs are held in flops that are loaded with the decode of the
// *next* state. They therefore always equal the decode of the current state,
// and they are glitch-free. The asynchronous reset also clears them at once,
// so no memory or register-file write can follow the assertion of Reset_L.
// ---------------------------------------------------------------------------
module multicycle_control (
   input  logic       CLK,
   input  logic       Reset_L,
   input  logic [5:0] Opcode,
   input  logic       Zero,
   output logic [3:0] ALUOp,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic       PCEn,
   output logic       IllegalOp,
   output logic [3:0] State
);

   // State encoding is fixed, because State is visible on the debug port.
   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEMADDR   = 4'd2;
   localparam logic [3:0] S_MEMREAD   = 4'd3;
   localparam logic [3:0] S_MEMWB     = 4'd4;
   localparam logic [3:0] S_MEMWRITE  = 4'd5;
   localparam logic [3:0] S_EXEC      = 4'd6;
   localparam logic [3:0] S_RCOMPLETE = 4'd7;
   localparam logic [3:0] S_BRANCH    = 4'd8;
   localparam logic [3:0] S_JUMP      = 4'd9;
   localparam logic [3:0] S_IEXEC     = 4'd10;
   localparam logic [3:0] S_ICOMPLETE = 4'd11;
   localparam logic [3:0] S_INIT      = 4'd12;

   // Supported opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   // ALUOp codes
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_RTYPE = 4'b0010;
   localparam logic [3:0] ALU_ADDI  = 4'b0100;
   localparam logic [3:0] ALU_ADDIU = 4'b0101;
   localparam logic [3:0] ALU_ANDI  = 4'b0110;
   localparam logic [3:0] ALU_ORI   = 4'b0111;

   // The complete set of Moore outputs, kept together so that one flop bank
   // and one decode function cover all of them.
   typedef struct packed {
      logic [3:0] alu_op;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{
      alu_op: 4'b0000, iord: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
      ir_write: 1'b0, mem_to_reg: 1'b0, reg_dst: 1'b0, reg_write: 1'b0,
      alu_src_a: 1'b0, pc_write: 1'b0, pc_write_cond: 1'b0,
      alu_src_b: 2'b00, pc_source: 2'b00
   };

   // Returns 1 for the opcodes that this controller implements.
   function automatic logic is_legal(input logic [5:0] op);
      logic legal;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
         OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: legal = 1'b1;
         default:                            legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Returns the ALU code for an immediate-format arithmetic or logic opcode.
   function automatic logic [3:0] iexec_alu_op(input logic [5:0] op);
      logic [3:0] code;
      case (op)
         OP_ADDI:  code = ALU_ADDI;
         OP_ADDIU: code = ALU_ADDIU;
         OP_ANDI:  code = ALU_ANDI;
         OP_ORI:   code = ALU_ORI;
         default:  code = ALU_ADD;
      endcase
      return code;
   endfunction

   // Decodes the control word for a state. The opcode argument matters only
   // in IEXEC, and there it must be the opcode that was latched in DECODE.
   function automatic ctl_t decode_ctl(input logic [3:0] st, input logic [5:0] op);
      ctl_t c;
      c = CTL_IDLE;
      case (st)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
         end
         S_MEMADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMREAD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEMWRITE: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_RTYPE;
         end
         S_RCOMPLETE: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         S_IEXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_op    = iexec_alu_op(op);
         end
         S_ICOMPLETE: begin
            c.reg_write = 1'b1;
         end
         // INIT and the unused encodings 13-15 drive nothing.
         default: begin
            c = CTL_IDLE;
         end
      endcase
      return c;
   endfunction

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic [5:0] opcode_q;
   logic [5:0] opcode_d;
   ctl_t       ctl_q;
   ctl_t       ctl_d;

   // Next-state sequencing. The opcode is captured only in DECODE.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      case (state_q)
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            opcode_d = Opcode;
            case (Opcode)
               OP_LW, OP_SW:                        state_d = S_MEMADDR;
               OP_RTYPE:                            state_d = S_EXEC;
               OP_BEQ:                              state_d = S_BRANCH;
               OP_J:                                state_d = S_JUMP;
               OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI:  state_d = S_IEXEC;
               default:                             state_d = S_FETCH;
            endcase
         end
         S_MEMADDR: begin
            // Only lw or sw can reach MEMADDR, so sw selects the store path
            // and anything else selects the load path.
            if (opcode_q == OP_SW) begin
               state_d = S_MEMWRITE;
            end else begin
               state_d = S_MEMREAD;
            end
         end
         S_MEMREAD:   state_d = S_MEMWB;
         S_MEMWB:     state_d = S_FETCH;
         S_MEMWRITE:  state_d = S_FETCH;
         S_EXEC:      state_d = S_RCOMPLETE;
         S_RCOMPLETE: state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         S_IEXEC:     state_d = S_ICOMPLETE;
         S_ICOMPLETE: state_d = S_FETCH;
         // INIT and the unused encodings 13-15 all move to FETCH.
         default:     state_d = S_FETCH;
      endcase
   end

   // Control word for the coming state. opcode_d already holds the opcode
   // that IEXEC will use when that state is entered from DECODE.
   always_comb begin
      ctl_d = decode_ctl(state_d, opcode_d);
   end

   // State, latched opcode and registered control word.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q  <= S_INIT;
         opcode_q <= 6'b000000;
         ctl_q    <= CTL_IDLE;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         ctl_q    <= ctl_d;
      end
   end

   assign ALUOp       = ctl_q.alu_op;
   assign IorD        = ctl_q.iord;
   assign MemRead     = ctl_q.mem_read;
   assign MemWrite    = ctl_q.mem_write;
   assign IRWrite     = ctl_q.ir_write;
   assign MemtoReg    = ctl_q.mem_to_reg;
   assign RegDst      = ctl_q.reg_dst;
   assign RegWrite    = ctl_q.reg_write;
   assign ALUSrcA     = ctl_q.alu_src_a;
   assign PCWrite     = ctl_q.pc_write;
   assign PCWriteCond = ctl_q.pc_write_cond;
   assign ALUSrcB     = ctl_q.alu_src_b;
   assign PCSource    = ctl_q.pc_source;
   assign State       = state_q;

   // The branch PC enable must track Zero within the BRANCH cycle, so it is
   // combinational. It is still 0 in reset because the control flops are
   // cleared.
   assign PCEn = ctl_q.pc_write | (ctl_q.pc_write_cond & Zero);

   // The instruction register is stable during DECODE, so this pulse lasts
   // exactly one cycle. During reset state_q is INIT, which holds it low.
   assign IllegalOp = (state_q == S_DECODE) & ~is_legal(Opcode);

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control. A behavioural model derives
// the state path of each instruction class and the control word expected in
// every state. Directed instructions, resets and random instructions with
// random Opcode/Zero noise are checked against that model.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

   logic       CLK = 1'b0;
   logic       Reset_L = 1'b1;
   logic [5:0] Opcode = 6'b000000;
   logic       Zero = 1'b0;
   logic [3:0] ALUOp;
   logic       IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
   logic       ALUSrcA, PCWrite, PCWriteCond, PCEn, IllegalOp;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] State;

   int n_checks = 0;
   int n_fails  = 0;

   multicycle_control dut (
      .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .Zero(Zero),
      .ALUOp(ALUOp), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite),
      .PCWriteCond(PCWriteCond), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .PCEn(PCEn), .IllegalOp(IllegalOp), .State(State)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] aluop;
      logic iord, mr, mw, irw, m2r, rdst, rw, asa, pcw, pcwc;
      logic [1:0] asb, pcs;
      logic pcen, ill;
      logic [3:0] st;
   } obs_t;

   typedef int path_t[$];

   obs_t observed;
   assign observed = {ALUOp, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                      RegWrite, ALUSrcA, PCWrite, PCWriteCond, ALUSrcB, PCSource,
                      PCEn, IllegalOp, State};

   localparam logic [5:0] LEGAL [9] = '{6'b000000, 6'b100011, 6'b101011,
                                        6'b000100, 6'b000010, 6'b001000,
                                        6'b001001, 6'b001100, 6'b001101};
   // addi, addiu, andi, ori map to ALUOp 4 + index
   localparam logic [5:0] IOPS [4] = '{6'b001000, 6'b001001, 6'b001100, 6'b001101};

   function automatic bit legal_op(input logic [5:0] op);
      foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] imm_aluop(input logic [5:0] op);
      foreach (IOPS[i]) if (IOPS[i] == op) return 4'(4 + i);
      return 4'd0;
   endfunction

   // States visited from FETCH up to (not including) the next FETCH
   function automatic path_t path_for(input logic [5:0] op);
      path_t p;
      p = '{0, 1};
      if (op == 6'b100011)      p = '{0, 1, 2, 3, 4};
      else if (op == 6'b101011) p = '{0, 1, 2, 5};
      else if (op == 6'b000000) p = '{0, 1, 6, 7};
      else if (op == 6'b000100) p = '{0, 1, 8};
      else if (op == 6'b000010) p = '{0, 1, 9};
      else if (imm_aluop(op) != 4'd0) p = '{0, 1, 10, 11};
      return p;
   endfunction

   // Expected outputs in a state; lat_op is the instruction, cur_op the
   // present Opcode input, zero the present Zero input.
   function automatic obs_t exp_out(input int st, input logic [5:0] lat_op,
                                    input logic zero, input logic [5:0] cur_op);
      obs_t e;
      e = '0;
      e.st = 4'(st);
      case (st)
         0:  begin e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; e.asb = 2'b01; e.pcen = 1'b1; end
         1:  begin e.asb = 2'b11; e.ill = !legal_op(cur_op); end
         2:  begin e.asa = 1'b1; e.asb = 2'b10; end
         3:  begin e.mr = 1'b1; e.iord = 1'b1; end
         4:  begin e.rw = 1'b1; e.m2r = 1'b1; end
         5:  begin e.mw = 1'b1; e.iord = 1'b1; end
         6:  begin e.asa = 1'b1; e.aluop = 4'b0010; end
         7:  begin e.rw = 1'b1; e.rdst = 1'b1; end
         8:  begin e.asa = 1'b1; e.aluop = 4'b0001; e.pcwc = 1'b1; e.pcs = 2'b01; e.pcen = zero; end
         9:  begin e.pcw = 1'b1; e.pcs = 2'b10; e.pcen = 1'b1; end
         10: begin e.asa = 1'b1; e.asb = 2'b10; e.aluop = imm_aluop(lat_op); end
         11: begin e.rw = 1'b1; end
         default: e.st = 4'd12;
      endcase
      return e;
   endfunction

   task automatic check(input string tag, input obs_t exp);
      n_checks++;
      assert (observed === exp)
      else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   // Runs one instruction starting in FETCH. zmode: 0/1 force Zero, 2 random.
   // hold_fixed drives hold_op on Opcode outside DECODE instead of noise.
   // rst_at: state in which Reset_L is asserted mid-instruction (-1 = never).
   task automatic run_instr(input logic [5:0] op, input int zmode,
                            input bit hold_fixed, input logic [5:0] hold_op,
                            input int rst_at);
      path_t p;
      p = path_for(op);
      foreach (p[i]) begin
         if (p[i] == 1) Opcode = op;
         else if (hold_fixed) Opcode = hold_op;
         else Opcode = 6'($urandom);
         Zero = (zmode == 2) ? 1'($urandom) : zmode[0];
         #1;
         check($sformatf("op%b_st%0d", op, p[i]), exp_out(p[i], op, Zero, Opcode));
         if (p[i] == rst_at) begin
            Reset_L = 1'b0;
            Zero = 1'b1;
            #1;
            check("mid_reset_immediate", exp_out(12, op, Zero, Opcode));
            tick();
            check("mid_reset_held", exp_out(12, op, Zero, Opcode));
            Reset_L = 1'b1;
            #1;
            check("mid_reset_dead_cycle", exp_out(12, op, Zero, Opcode));
            tick();
            return;
         end
         tick();
      end
   endtask

   initial begin
      logic [5:0] op;
      // Reset asserted asynchronously, held for 3 cycles
      Zero = 1'b1;
      #1 Reset_L = 1'b0;
      #1;
      check("reset_async", exp_out(12, 6'd0, Zero, Opcode));
      for (int i = 0; i < 3; i++) begin
         tick();
         Opcode = 6'($urandom);
         #1;
         check($sformatf("reset_hold%0d", i), exp_out(12, 6'd0, Zero, Opcode));
      end
      Reset_L = 1'b1;
      #1;
      check("reset_dead_cycle", exp_out(12, 6'd0, Zero, Opcode));
      tick();

      // Directed instructions
      run_instr(6'b100011, 2, 1'b0, 6'd0, -1);     // lw
      run_instr(6'b101011, 2, 1'b0, 6'd0, -1);     // sw
      run_instr(6'b000000, 2, 1'b0, 6'd0, -1);     // R-type
      run_instr(6'b000100, 1, 1'b0, 6'd0, -1);     // beq taken
      run_instr(6'b000100, 0, 1'b0, 6'd0, -1);     // beq not taken
      run_instr(6'b001101, 2, 1'b1, 6'b000000, -1); // ori, Opcode -> 0 afterwards
      run_instr(6'b001000, 2, 1'b1, 6'b000000, -1); // addi
      run_instr(6'b001001, 2, 1'b1, 6'b000000, -1); // addiu
      run_instr(6'b001100, 2, 1'b1, 6'b000000, -1); // andi
      run_instr(6'b000010, 2, 1'b0, 6'd0, -1);     // j
      run_instr(6'b111111, 2, 1'b0, 6'd0, -1);     // illegal
      run_instr(6'b100011, 2, 1'b0, 6'd0, 3);      // lw, reset in MEMREAD
      run_instr(6'b101011, 2, 1'b1, 6'b100011, -1); // sw, Opcode noise = lw

      // Random instruction mix
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) == 0) op = 6'($urandom);
         else op = LEGAL[$urandom_range(0, 8)];
         run_instr(op, 2, 1'b0, 6'd0, ($urandom_range(0, 15) == 0) ? 1 : -1);
      end

      Zero = 1'b0;
      #1;
      check("final_fetch", exp_out(0, 6'd0, Zero, Opcode));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
